// File: rtl/pulse_event_arbiter.sv
// Multi-channel rising-edge collector with round-robin valid/ready drain.
// Optional input debounce filter enabled by defining PULSE_ARB_DEBOUNCE_EN.
module pulse_event_arbiter #(
  parameter int N_CH    = 4,
  parameter int DEB_CYC = 3,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   noise,
  input  logic [N_CH-1:0]   ch_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [N_CH-1:0]   ovf,
  input  logic              ovf_clr
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;
  logic [N_CH-1:0]   u_q, v_q;
  logic [N_CH-1:0]   edge_w;
  logic [N_CH-1:0]   grant_vec;
  logic [N_CH-1:0]   avail;
  logic [N_CH-1:0]   ovf_set;
  logic              found;
  logic [CH_W-1:0]   sel;
  logic [CH_W:0]     idx_sum;
  logic [CH_W-1:0]   idx;

  // Two-flop synchronizer; the edge detector taps the second stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_q <= '0;
      v_q <= '0;
    end else begin
      u_q <= noise;
      v_q <= u_q;
    end
  end

`ifdef PULSE_ARB_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYC + 1);

  // A level change is accepted only after DEB_CYC consecutive cycles of disagreement.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic             f_q;
    logic             f_dly_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q   <= '0;
        f_q     <= 1'b0;
        f_dly_q <= 1'b0;
      end else begin
        f_dly_q <= f_q;
        if (v_q[gi] != f_q) begin
          if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
            f_q   <= v_q[gi];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign edge_w[gi] = f_q & ~f_dly_q;
  end
`else
  logic [N_CH-1:0] w_q;

  always_ff @(posedge clk) begin
    if (rst) w_q <= '0;
    else     w_q <= v_q;
  end

  assign edge_w = v_q & ~w_q;
`endif

  // Pending bits of disabled channels are about to be dropped, so never grant them.
  assign avail = pend_q & ch_en;

  always_comb begin
    found   = 1'b0;
    sel     = '0;
    idx_sum = '0;
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx_sum = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (idx_sum >= (CH_W + 1)'(N_CH)) idx_sum = idx_sum - (CH_W + 1)'(N_CH);
      idx = idx_sum[CH_W-1:0];
      if (!found && avail[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    grant_vec = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = OFFER;
          valid_d        = 1'b1;
          ch_d           = sel;
          ptr_d          = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
          grant_vec[sel] = 1'b1;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          if (found) begin
            valid_d        = 1'b1;
            ch_d           = sel;
            ptr_d          = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
            grant_vec[sel] = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // A fresh edge outranks the grant clear; it is only an overflow if the old event stays queued.
  always_comb begin
    ovf_set = edge_w & ch_en & pend_q & ~grant_vec;
    pend_d  = ((pend_q & ~grant_vec) | (edge_w & ch_en)) & ch_en;
    ovf_d   = (ovf_q & ~{N_CH{ovf_clr}}) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_ch    = ch_q;
  assign ovf       = ovf_q;

endmodule
